wb_writeback_arbiter: RTL and testbench
=======================================

# wb_writeback_arbiter

Consumes the ten clock-domain-crossed writeback streams (CQ head, SQ PSN, last RQ request, seven packet counters) on the out-clock side of the writeback CDC stage. Each arriving value lands in a per-source holding slot with a pending flag; a round-robin arbiter serialises pending slots into single memory-write requests toward the host writeback area. A newer value for a still-pending slot replaces the older one, so only the latest value per source is written.

## Interface
Parameters:
- NUM_SRC, 10, number of writeback sources; slot index order CQHEADi, SQPSNi, LSTRQREQi, INSRRPKTCNT, INAMPKTCNT, INNCKPKTSTS, OUTAMPKTCNT, OUTNAKPKTCNT, OUTIOPKTCNT, OUTRDRSPPKTCNT
- SRC_W, 40, per-slot data width; 32- and 16-bit sources are zero-extended by the instantiating level
- ADDR_W, 64, write address width
- SLOT_STRIDE, 8, byte distance between slot addresses

Ports:
- clk_i  in  1  single clock (out-clock domain of the CDC stage)
- rstn_i  in  1  reset; asynchronous, active-low
- wb_valid_i  in  NUM_SRC  per-slot valid from CDC stage
- wb_data_i  in  NUM_SRC*SRC_W  packed slot data, slot 0 in LSBs
- wb_ready_o  out  1  shared ready back to CDC stage
- wb_base_addr_i  in  ADDR_W  host writeback area base, quasi-static
- wr_valid_o  out  1  write request valid
- wr_ready_i  in  1  write request accepted
- wr_addr_o  out  ADDR_W  base + slot*SLOT_STRIDE
- wr_data_o  out  64  slot data zero-extended to 64 bits
- wr_done_i  in  1  single-cycle completion pulse for the outstanding write
- busy_o  out  1  any pending flag set or FSM not IDLE

## Operation
- Capture: for each slot s with wb_valid_i[s] && wb_ready_o, data -> hold[s], pend[s] <= 1. Overwrite of a pending slot is silent (latest wins).
- wb_ready_o: 0 in reset, 1 from the first clock edge after reset release, constant thereafter; capture never stalls the CDC stage.
- Arbiter: round-robin; search starts at rr_ptr, first pend[s]=1 at or after it (wrapping 9 -> 0) wins. After grant rr_ptr <= (s+1) mod NUM_SRC.
- FSM: IDLE -> (any pend) GRANT latch: wr_addr_o/wr_data_o <= slot address/hold[s], pend[s] <= 0 -> REQ (wr_valid_o=1) -> on wr_valid_o&&wr_ready_i -> WAIT -> on wr_done_i -> IDLE.
- wr_done_i outside WAIT is ignored. wr_addr_o/wr_data_o stable while wr_valid_o high.
- Simultaneous capture and grant on same slot in one cycle: grant takes the old hold value, new value written to hold[s], pend[s] stays 1 (capture wins over clear).
- Address arithmetic: ADDR_W-bit add, wraps modulo 2^ADDR_W, no overflow flag.

## Timing
- Reset values: wb_ready_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, all pend=0, rr_ptr=0, FSM=IDLE.
- Capture edge N -> pend visible N+1 -> GRANT registered at N+1 edge if IDLE -> wr_valid_o high from cycle N+2 (two-cycle latency, input to request).
- Back-to-back: after wr_done_i at edge M, IDLE at M; next grant at M+1; wr_valid_o at M+2. Minimum 4 cycles per write with zero-wait ready/done.
- Reset asserted mid-write drops the outstanding request and all pending values; wr_valid_o falls asynchronously.

## Configuration
- WB_OVERWRITE_CNT_EN defined: adds output ovw_cnt_o (16 bits, reset 0), incremented once per cycle in which at least one capture hits a slot whose pend is already 1 and is not being granted that cycle; saturates at 0xFFFF.
- Undefined: port and counter absent; overwrite behaviour otherwise identical.

## Structure
- Shared package wb_pkg: slot index enum (order above), NUM_SRC, SLOT_STRIDE, FSM state typedef (IDLE, GRANT, REQ, WAIT).
- One sub-module: wb_rr_arbiter (NUM_SRC request vector + pointer -> one-hot grant, index, any_req); combinational, pointer register stays in the parent.

## Test plan
- Single capture slot 2 data 0x12_3456_789A, base 0x1000_0000, ready/done immediate -> one write addr 0x1000_0010 data 0x0000_0012_3456_789A, wr_valid_o rises 2 cycles after capture.
- All 10 valids in one cycle, wr_ready_i held 0 for 5 cycles then 1 -> ten writes in slot order 0..9, busy_o falls after last done.
- Slot 5 captured 0xA then 0xB while write of slot 0 stalled -> exactly one slot-5 write with 0xB; with WB_OVERWRITE_CNT_EN ovw_cnt_o=1.
- Capture slot 3 in the exact GRANT cycle of slot 3 -> old value written, second slot-3 write with new value follows.
- rr_ptr at 9 after grant of slot 8, pend {9,1} -> slot 9 then slot 1 (wrap).
- rstn_i pulsed low while in WAIT with 3 slots pending -> all outputs reset values, no writes after release until new capture; stray wr_done_i ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback arbiter: slot order, default
// widths and the arbiter FSM state encoding.
package wb_pkg;

    localparam int WB_NUM_SRC     = 10;
    localparam int WB_SRC_W       = 40;
    localparam int WB_ADDR_W      = 64;
    localparam int WB_SLOT_STRIDE = 8;
    localparam int WB_DATA_W      = 64;

    // Slot index order; the host writeback area layout follows this order.
    typedef enum logic [3:0] {
        SLOT_CQHEAD         = 4'd0,
        SLOT_SQPSN          = 4'd1,
        SLOT_LSTRQREQ       = 4'd2,
        SLOT_INSRRPKTCNT    = 4'd3,
        SLOT_INAMPKTCNT     = 4'd4,
        SLOT_INNCKPKTSTS    = 4'd5,
        SLOT_OUTAMPKTCNT    = 4'd6,
        SLOT_OUTNAKPKTCNT   = 4'd7,
        SLOT_OUTIOPKTCNT    = 4'd8,
        SLOT_OUTRDRSPPKTCNT = 4'd9
    } wb_slot_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_REQ   = 2'd2,
        ST_WAIT  = 2'd3
    } wb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping
// from the last slot back to slot 0. The pointer register lives in the parent.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC,
    parameter int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_req_o
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum = {1'b0, ptr_i} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_SRC)) begin
                sum = sum - SUM_W'(NUM_SRC);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/wb_writeback_arbiter.sv
// Holds the latest value of each CDC writeback source and serialises pending
// slots into single host memory writes. Optional: WB_OVERWRITE_CNT_EN adds ovw_cnt_o.
module wb_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC     = WB_NUM_SRC,
    parameter int SRC_W       = WB_SRC_W,
    parameter int ADDR_W      = WB_ADDR_W,
    parameter int SLOT_STRIDE = WB_SLOT_STRIDE
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NUM_SRC-1:0]       wb_valid_i,
    input  logic [NUM_SRC*SRC_W-1:0] wb_data_i,
    output logic                     wb_ready_o,
    input  logic [ADDR_W-1:0]        wb_base_addr_i,
    output logic                     wr_valid_o,
    input  logic                     wr_ready_i,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [WB_DATA_W-1:0]     wr_data_o,
    input  logic                     wr_done_i,
    output logic                     busy_o,
`ifdef WB_OVERWRITE_CNT_EN
    output logic [15:0]              ovw_cnt_o,
`endif
    output wb_state_e                fsm_state_o
);

    localparam int IDX_W = idx_width(NUM_SRC);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits for ready and its payload holds until taken.
    logic                 rdy_q;
    logic [NUM_SRC-1:0]   pend_q;
    logic [SRC_W-1:0]     hold_q [NUM_SRC];
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [WB_DATA_W-1:0] data_q;
    wb_state_e            state_q, state_d;

    logic [NUM_SRC-1:0]   capture;
    logic [NUM_SRC-1:0]   gnt;
    logic [NUM_SRC-1:0]   grant_vec;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 any_req;
    logic                 grant_fire;

    assign capture    = wb_valid_i & {NUM_SRC{rdy_q}};
    assign grant_fire = (state_q == ST_IDLE) && any_req;
    assign grant_vec  = grant_fire ? gnt : '0;

    wb_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i     (pend_q),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_req_o (any_req)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // A capture in the grant cycle keeps the slot pending: the grant takes the
    // old value and the new one is written on a later turn.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                hold_q[s] <= '0;
            end
        end else begin
            pend_q <= (pend_q & ~grant_vec) | capture;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (capture[s]) begin
                    hold_q[s] <= wb_data_i[s*SRC_W +: SRC_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q   <= '0;
            data_q   <= '0;
            rr_ptr_q <= '0;
        end else if (grant_fire) begin
            addr_q   <= wb_base_addr_i + ADDR_W'(gnt_idx) * ADDR_W'(SLOT_STRIDE);
            data_q   <= WB_DATA_W'(hold_q[gnt_idx]);
            rr_ptr_q <= (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req)    state_d = ST_GRANT;
            ST_GRANT:                 state_d = ST_REQ;
            ST_REQ:   if (wr_ready_i) state_d = ST_WAIT;
            ST_WAIT:  if (wr_done_i)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

`ifdef WB_OVERWRITE_CNT_EN
    logic [15:0] ovw_cnt_q;
    logic        ovw_hit;

    assign ovw_hit = |(capture & pend_q & ~grant_vec);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovw_cnt_q <= '0;
        end else if (ovw_hit && (ovw_cnt_q != 16'hFFFF)) begin
            ovw_cnt_q <= ovw_cnt_q + 16'd1;
        end
    end

    assign ovw_cnt_o = ovw_cnt_q;
`endif

    assign wb_ready_o  = rdy_q;
    assign wr_valid_o  = (state_q == ST_REQ);
    assign wr_addr_o   = addr_q;
    assign wr_data_o   = data_q;
    assign busy_o      = (|pend_q) || (state_q != ST_IDLE);
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_wb_writeback_arbiter.sv
// Bench for wb_writeback_arbiter: directed scenarios plus randomized traffic,
// checked each cycle against a slot/queue reference model. Honours WB_OVERWRITE_CNT_EN.
module tb_wb_writeback_arbiter;
    import wb_pkg::*;

    localparam int N  = 10;
    localparam int SW = 40;
    localparam int AW = 64;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b1;
    logic [N-1:0]    wb_valid_i = '0;
    logic [N*SW-1:0] wb_data_i = '0;
    logic            wb_ready_o;
    logic [AW-1:0]   wb_base_addr_i = '0;
    logic            wr_valid_o;
    logic            wr_ready_i = 1'b1;
    logic [AW-1:0]   wr_addr_o;
    logic [63:0]     wr_data_o;
    logic            wr_done_i = 1'b0;
    logic            busy_o;
    wb_state_e       fsm_state;
`ifdef WB_OVERWRITE_CNT_EN
    logic [15:0]     ovw_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    wb_writeback_arbiter dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .wb_valid_i     (wb_valid_i),
        .wb_data_i      (wb_data_i),
        .wb_ready_o     (wb_ready_o),
        .wb_base_addr_i (wb_base_addr_i),
        .wr_valid_o     (wr_valid_o),
        .wr_ready_i     (wr_ready_i),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .wr_done_i      (wr_done_i),
        .busy_o         (busy_o),
`ifdef WB_OVERWRITE_CNT_EN
        .ovw_cnt_o      (ovw_cnt_o),
`endif
        .fsm_state_o    (fsm_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: latest value per slot, pending flags, round-robin pointer
    // and the one write currently in flight ({addr, data}).
    bit            m_pend [N];
    logic [SW-1:0] m_val  [N];
    int            m_ptr;
    bit            m_ready;
    bit            m_inflight;
    bit            m_accepted;
    int            m_age;
    logic [127:0]  m_cur;
    int            m_ovw;
    logic [127:0]  exp_q [$];
    logic [127:0]  act_q [$];

    int ready_mode;
    int done_max;
    bit stray_en;
    bit resp_pending;
    int resp_wait;

    task automatic model_clear();
        for (int s = 0; s < N; s++) begin
            m_pend[s] = 1'b0;
            m_val[s]  = '0;
        end
        m_ptr = 0; m_ready = 1'b0; m_inflight = 1'b0; m_accepted = 1'b0;
        m_age = 0; m_cur = '0; m_ovw = 0;
        exp_q.delete();
        act_q.delete();
        resp_pending = 1'b0;
        resp_wait = 0;
    endtask

    task automatic model_edge();
        bit was_idle;
        bit hit;
        was_idle = !m_inflight;
        hit = 1'b0;
        if (m_inflight) begin
            if (m_accepted) begin
                if (wr_done_i) m_inflight = 1'b0;
            end else if (m_age >= 1 && wr_ready_i) begin
                m_accepted = 1'b1;
            end
            m_age++;
        end
        if (was_idle) begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (m_pend[s]) begin
                    m_cur = {wb_base_addr_i + 64'(s) * 64'd8, 64'(m_val[s])};
                    exp_q.push_back(m_cur);
                    m_pend[s] = 1'b0;
                    m_ptr = (s + 1) % N;
                    m_inflight = 1'b1;
                    m_accepted = 1'b0;
                    m_age = 0;
                    break;
                end
            end
        end
        if (m_ready) begin
            for (int s = 0; s < N; s++) begin
                if (wb_valid_i[s]) begin
                    if (m_pend[s]) hit = 1'b1;
                    m_pend[s] = 1'b1;
                    m_val[s]  = wb_data_i[s*SW +: SW];
                end
            end
        end
        if (hit && m_ovw < 65535) m_ovw++;
        m_ready = 1'b1;
    endtask

    task automatic check_outputs();
        bit ev;
        bit ap;
        ev = m_inflight && !m_accepted && (m_age >= 1);
        ap = 1'b0;
        for (int s = 0; s < N; s++) ap = ap | m_pend[s];
        check_eq("wb_ready", 128'(wb_ready_o), 128'(m_ready));
        check_eq("wr_valid", 128'(wr_valid_o), 128'(ev));
        check_eq("busy", 128'(busy_o), 128'(ap || m_inflight));
        if (ev) begin
            check_eq("wr_addr", 128'(wr_addr_o), 128'(m_cur[127:64]));
            check_eq("wr_data", 128'(wr_data_o), 128'(m_cur[63:0]));
        end
`ifdef WB_OVERWRITE_CNT_EN
        check_eq("ovw_cnt", 128'(ovw_cnt_o), 128'(m_ovw));
`endif
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0:       wr_ready_i = 1'b1;
            1:       wr_ready_i = 1'($urandom_range(0, 1));
            default: wr_ready_i = 1'b0;
        endcase
    endtask

    task automatic set_ready(input int m);
        ready_mode = m;
        drive_ready();
    endtask

    task automatic cycle();
        if (wr_valid_o && wr_ready_i) begin
            logic [127:0] got;
            got = {wr_addr_o, wr_data_o};
            act_q.push_back(got);
            if (exp_q.size() == 0) check_eq("unexpected_write", 128'(1), 128'(0));
            else check_eq("sb_write", got, exp_q.pop_front());
            resp_pending = 1'b1;
            resp_wait = $urandom_range(0, done_max);
        end
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        wb_valid_i = '0;
        check_outputs();
        wr_done_i = 1'b0;
        if (resp_pending) begin
            if (resp_wait == 0) begin
                wr_done_i = 1'b1;
                resp_pending = 1'b0;
            end else begin
                resp_wait--;
            end
        end else if (stray_en && $urandom_range(0, 5) == 0) begin
            wr_done_i = 1'b1;
        end
        drive_ready();
    endtask

    task automatic put(input int s, input logic [SW-1:0] d);
        wb_valid_i[s] = 1'b1;
        wb_data_i[s*SW +: SW] = d;
    endtask

    task automatic do_reset(input string tag);
        #2 rstn_i = 1'b0;
        #1;
        check_eq({tag, "_rst_wr_valid"}, 128'(wr_valid_o), 128'(0));
        check_eq({tag, "_rst_wr_addr"}, 128'(wr_addr_o), 128'(0));
        check_eq({tag, "_rst_wr_data"}, 128'(wr_data_o), 128'(0));
        check_eq({tag, "_rst_busy"}, 128'(busy_o), 128'(0));
        check_eq({tag, "_rst_wb_ready"}, 128'(wb_ready_o), 128'(0));
        check_eq({tag, "_rst_state"}, 128'(fsm_state), 128'(ST_IDLE));
`ifdef WB_OVERWRITE_CNT_EN
        check_eq({tag, "_rst_ovw"}, 128'(ovw_cnt_o), 128'(0));
`endif
        model_clear();
        wb_valid_i = '0;
        wr_done_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while ((busy_o || resp_pending || exp_q.size() != 0) && k < budget) begin
            cycle();
            k++;
        end
        check_eq({tag, "_drained"}, 128'(busy_o || resp_pending || exp_q.size() != 0), 128'(0));
    endtask

    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;

    initial begin
        logic [SW-1:0] d [N];
        ready_mode = 0; done_max = 0; stray_en = 1'b0;
        model_clear();
        wb_base_addr_i = BASE;
        @(negedge clk_i);

        // single capture on slot 2, latency and address/data
        do_reset("t1");
        cycle();
        put(2, 40'h12_3456_789A);
        cycle();
        cycle();
        check_eq("t1_valid_n1", 128'(wr_valid_o), 128'(0));
        cycle();
        check_eq("t1_valid_n2", 128'(wr_valid_o), 128'(1));
        wait_idle("t1", 50);
        check_eq("t1_count", 128'(act_q.size()), 128'(1));
        check_eq("t1_write", act_q[0], {64'h0000_0000_1000_0010, 64'h0000_0012_3456_789A});

        // all ten sources at once with a stalled write port
        do_reset("t2");
        cycle();
        set_ready(2);
        for (int s = 0; s < N; s++) begin
            d[s] = {8'($urandom), 32'($urandom)};
            put(s, d[s]);
        end
        cycle();
        repeat (5) cycle();
        set_ready(0);
        wait_idle("t2", 200);
        check_eq("t2_count", 128'(act_q.size()), 128'(N));
        for (int s = 0; s < N; s++) begin
            check_eq($sformatf("t2_write%0d", s), act_q[s], {BASE + 64'(s * 8), 64'(d[s])});
        end
        check_eq("t2_busy", 128'(busy_o), 128'(0));

        // slot 5 overwritten while slot 0 stalls
        do_reset("t3");
        cycle();
        set_ready(2);
        put(0, 40'h77); cycle();
        put(5, 40'hA);  cycle();
        put(5, 40'hB);  cycle();
        repeat (3) cycle();
        set_ready(0);
        wait_idle("t3", 100);
        check_eq("t3_count", 128'(act_q.size()), 128'(2));
        check_eq("t3_slot5", act_q[1], {BASE + 64'd40, 64'hB});
`ifdef WB_OVERWRITE_CNT_EN
        check_eq("t3_ovw", 128'(ovw_cnt_o), 128'(1));
`endif

        // capture on slot 3 in its own grant cycle
        do_reset("t4");
        cycle();
        put(3, 40'h111); cycle();
        put(3, 40'h222); cycle();
        wait_idle("t4", 100);
        check_eq("t4_count", 128'(act_q.size()), 128'(2));
        check_eq("t4_old", act_q[0], {BASE + 64'd24, 64'h111});
        check_eq("t4_new", act_q[1], {BASE + 64'd24, 64'h222});
`ifdef WB_OVERWRITE_CNT_EN
        check_eq("t4_ovw", 128'(ovw_cnt_o), 128'(0));
`endif

        // pointer wrap: grant 8, then pend {9,1}
        do_reset("t5");
        cycle();
        put(8, 40'h8); cycle();
        wait_idle("t5a", 50);
        put(9, 40'h9); put(1, 40'h1); cycle();
        wait_idle("t5b", 100);
        check_eq("t5_count", 128'(act_q.size()), 128'(3));
        check_eq("t5_first", act_q[1], {BASE + 64'd72, 64'h9});
        check_eq("t5_second", act_q[2], {BASE + 64'd8, 64'h1});

        // reset while waiting for done with three slots pending
        do_reset("t6a");
        cycle();
        done_max = 40;
        put(0, 40'h5); cycle();
        for (int k = 0; k < 10 && !resp_pending; k++) cycle();
        put(4, 40'h44); put(6, 40'h66); put(7, 40'h77); cycle();
        cycle();
        check_eq("t6_in_wait", 128'(fsm_state), 128'(ST_WAIT));
        do_reset("t6b");
        done_max = 0;
        stray_en = 1'b1;
        repeat (30) cycle();
        check_eq("t6_no_write", 128'(act_q.size()), 128'(0));
        stray_en = 1'b0;
        put(2, 40'h22); cycle();
        wait_idle("t6", 50);
        check_eq("t6_count", 128'(act_q.size()), 128'(1));

        // reset during an active request drops wr_valid_o at once
        do_reset("t7a");
        cycle();
        set_ready(2);
        put(1, 40'h1); cycle();
        repeat (3) cycle();
        do_reset("t7b");
        set_ready(0);

        // randomized traffic: wrapping base, then a random base
        for (int r = 0; r < 2; r++) begin
            do_reset($sformatf("r%0d", r));
            wb_base_addr_i = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFE0 : {32'($urandom), 32'($urandom)};
            set_ready(1);
            done_max = 3;
            stray_en = 1'b1;
            cycle();
            for (int c = 0; c < 800; c++) begin
                for (int s = 0; s < N; s++) begin
                    if ($urandom_range(0, 5) == 0) put(s, {8'($urandom), 32'($urandom)});
                end
                cycle();
            end
            set_ready(0);
            wait_idle($sformatf("r%0d", r), 400);
            stray_en = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
